// File: rtl/apb_master_pkg.sv
// Shared types and widths for the APB initiator (package apb_pkg).
package apb_pkg;

  localparam int APB_ADDR_W   = 32;
  localparam int APB_DATA_W   = 32;
  // Address bits [13:12] pick the slave slot; [31:14] must match the window base.
  localparam int APB_SLOT_LSB = 12;
  localparam int APB_WIN_LSB  = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// CPU-side request bus plus APB3 bus of the initiator, bundled as one interface.
// master modport = the bridge's view, slave modport = requester/peripheral side.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4
);

  // CPU side
  logic                                   transfer;
  logic                                   write;
  logic [APB_ADDR_W-1:0]                  addr;
  logic [APB_DATA_W-1:0]                  wdata;
  logic [APB_DATA_W-1:0]                  rdata;
  logic                                   ready;
  logic                                   err;

  // APB side
  logic [APB_ADDR_W-1:0]                  PADDR;
  logic [APB_DATA_W-1:0]                  PWDATA;
  logic                                   PWRITE;
  logic                                   PENABLE;
  logic [NUM_SLAVES-1:0]                  PSEL;
  logic [NUM_SLAVES-1:0][APB_DATA_W-1:0]  PRDATA;
  logic [NUM_SLAVES-1:0]                  PREADY;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );

endinterface

// File: rtl/apb_master_mux.sv
// Slave-side steering: picks PRDATA/PREADY of the latched slot and builds
// the one-hot PSEL vector. Purely combinational.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic                                  sel_en_i,
  input  logic [1:0]                            idx_i,
  input  logic [NUM_SLAVES-1:0][APB_DATA_W-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]                 pready_i,
  output logic [APB_DATA_W-1:0]                 prdata_o,
  output logic                                  pready_o,
  output logic [NUM_SLAVES-1:0]                 psel_o
);

  // Loop compare instead of direct indexing so a slot beyond NUM_SLAVES reads as 0.
  always_comb begin
    prdata_o = '0;
    pready_o = 1'b0;
    psel_o   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_i == 2'(i)) begin
        prdata_o  = prdata_i[i];
        pready_o  = pready_i[i];
        psel_o[i] = sel_en_i;
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: CPU transfer/ready bus -> SETUP/ACCESS sequencing on APB,
// with a 16 KB window split into up to four PSEL slots.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase with err after
// TIMEOUT_CYCLES cycles without PREADY from the selected slave.
module apb_master
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_master_if.master  bus
);

  // Elaboration-time parameter sanity
  if (NUM_SLAVES < 1 || NUM_SLAVES > 4) begin : g_bad_num_slaves
    $error("apb_master: NUM_SLAVES must be 1..4");
  end
  if (BASE_ADDR[APB_WIN_LSB-1:0] != '0) begin : g_bad_base
    $error("apb_master: BASE_ADDR must be 16 KB aligned");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e            state_q, state_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  hit_q, hit_d;
  logic [1:0]            idx_q, idx_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [1:0]            slot;
  logic                  hit;
  logic [APB_DATA_W-1:0] prdata_sel;
  logic                  pready_sel;
  logic [NUM_SLAVES-1:0] psel;
  logic                  timeout;

  // Window decode of the incoming CPU address
  assign slot = bus.addr[APB_SLOT_LSB +: 2];
  assign hit  = (bus.addr[APB_ADDR_W-1:APB_WIN_LSB] == BASE_ADDR[APB_ADDR_W-1:APB_WIN_LSB])
              && (int'(slot) < NUM_SLAVES);

`ifdef APB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Last permitted ACCESS cycle; PREADY in this same cycle still completes normally.
  assign timeout = (cnt_q == CNT_LAST);

  // ACCESS-phase cycle counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  apb_master_mux #(.NUM_SLAVES(NUM_SLAVES)) u_mux (
    .sel_en_i (hit_q && (state_q != IDLE)),
    .idx_i    (idx_q),
    .prdata_i (bus.PRDATA),
    .pready_i (bus.PREADY),
    .prdata_o (prdata_sel),
    .pready_o (pready_sel),
    .psel_o   (psel)
  );

  // PSEL/PENABLE derive from the state register so reset drops them at once.
  assign bus.PSEL    = psel;
  assign bus.PENABLE = (state_q == ACCESS);
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath; ready/err/rdata default to 0 so they pulse.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    hit_d    = hit_q;
    idx_d    = idx_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          paddr_d  = bus.addr;
          pwdata_d = bus.wdata;
          pwrite_d = bus.write;
          hit_d    = hit;
          idx_d    = slot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (hit_q) begin
          state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          // Decode miss: nothing on APB, complete with error.
          state_d = IDLE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      ACCESS: begin
`ifdef APB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (pready_sel) begin
          state_d = IDLE;
          ready_d = 1'b1;
          rdata_d = pwrite_q ? '0 : prdata_sel;
        end else if (timeout) begin
          state_d = IDLE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched request and CPU-side response registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed cases plus random transfers against a
// transaction-level model (window arithmetic + per-slave wait counts).
module tb_apb_master;
  import apb_pkg::*;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 16;
`ifdef APB_TIMEOUT_EN
  localparam int          STALL = 8;
`else
  localparam int          STALL = 100;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_if #(.NUM_SLAVES(NS)) bus();

  apb_master #(.NUM_SLAVES(NS), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Slave models: selected slave raises PREADY after s_wait ACCESS cycles;
  // unselected slaves drive random junk that must be ignored.
  int                    s_wait [NS];
  logic [31:0]           s_data [NS];
  logic [NS-1:0]         noise_rdy;
  logic [NS-1:0][31:0]   noise_dat;
  int                    acc_cnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc_cnt <= 0;
    else        acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

  always_comb begin
    bus.PREADY = '0;
    bus.PRDATA = '0;
    for (int i = 0; i < NS; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        bus.PREADY[i] = (acc_cnt >= s_wait[i]);
        bus.PRDATA[i] = s_data[i];
      end else begin
        bus.PREADY[i] = noise_rdy[i];
        bus.PRDATA[i] = noise_dat[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    noise_rdy = NS'($urandom);
    for (int i = 0; i < NS; i++) noise_dat[i] = $urandom;
  endtask

  // Reference decode: plain offset arithmetic over the window.
  task automatic model(input logic [31:0] a, output bit hit, output int idx);
    logic [31:0] off;
    off = a - BASE;
    hit = (a >= BASE) && (off < 32'(NS * 4096));
    idx = hit ? int'(off / 4096) : 0;
  endtask

  task automatic idle(input int n);
    bus.transfer = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      chk("idle_ready", 32'(bus.ready), 32'd0);
      chk("idle_err", 32'(bus.err), 32'd0);
      chk("idle_psel", 32'(bus.PSEL), 32'd0);
      chk("idle_penable", 32'(bus.PENABLE), 32'd0);
    end
  endtask

  // Issue one transfer starting in the current cycle (FSM must be in IDLE)
  // and check every cycle up to and including the ready cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int w);
    bit          hit;
    int          idx;
    int          r;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  oh;
    model(a, hit, idx);
    if (hit) begin
      s_wait[idx] = w;
      s_data[idx] = rd;
    end
    oh      = hit ? (4'b0001 << idx) : 4'b0000;
    r       = hit ? 3 + w : 2;
    exp_err = !hit;
`ifdef APB_TIMEOUT_EN
    if (hit && w >= TO) begin
      r       = 2 + TO;
      exp_err = 1'b1;
    end
`endif
    exp_rd = (exp_err || wr) ? 32'd0 : rd;
    bus.transfer = 1'b1;
    bus.write    = wr;
    bus.addr     = a;
    bus.wdata    = wd;
    for (int k = 1; k <= r; k++) begin
      step();
      // Requester keeps transfer high; other fields wander and must be ignored.
      bus.addr  = $urandom;
      bus.wdata = $urandom;
      bus.write = 1'($urandom);
      if (k < r) begin
        chk("busy_ready", 32'(bus.ready), 32'd0);
        chk("busy_err", 32'(bus.err), 32'd0);
        chk("psel", 32'(bus.PSEL), 32'(oh));
        chk("penable", 32'(bus.PENABLE), {31'd0, hit && (k >= 2)});
        chk("paddr", bus.PADDR, a);
        chk("pwdata", bus.PWDATA, wd);
        chk("pwrite", 32'(bus.PWRITE), 32'(wr));
      end else begin
        chk("done_ready", 32'(bus.ready), 32'd1);
        chk("done_err", 32'(bus.err), 32'(exp_err));
        chk("done_rdata", bus.rdata, exp_rd);
        chk("done_psel", 32'(bus.PSEL), 32'd0);
        chk("done_penable", 32'(bus.PENABLE), 32'd0);
      end
    end
    bus.transfer = 1'b0;
  endtask

  initial begin
    bit          wr;
    logic [31:0] a;
    for (int i = 0; i < NS; i++) begin
      s_wait[i] = 0;
      s_data[i] = '0;
    end
    noise_rdy    = '0;
    noise_dat    = '0;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;

    // Reset state
    step();
    step();
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed cases
    xfer(1'b1, 32'h1000_0000, 32'h0000_00A5, 32'd0, 1);          // write slave 0, ready at cycle 4
    idle(2);
    xfer(1'b0, 32'h1000_2004, 32'h1111_1111, 32'h0000_003C, 1);  // read slave 2
    idle(1);
    xfer(1'b0, 32'h2000_0000, 32'd0, 32'hDEAD_BEEF, 0);          // decode miss
    idle(1);
    xfer(1'b1, 32'h1000_1010, 32'h1234_5678, 32'd0, 1);          // back-to-back: slave 1 ...
    xfer(1'b0, 32'h1000_3FFC, 32'd0, 32'hCAFE_F00D, 0);          // ... then slave 3
    idle(1);
    xfer(1'b0, 32'h1000_0008, 32'd0, 32'h8000_0001, 0);          // zero-wait minimum latency
    xfer(1'b0, 32'h0FFF_FFFC, 32'd0, 32'h5555_5555, 0);          // just below window
    xfer(1'b0, 32'h1000_4000, 32'd0, 32'h5555_5555, 0);          // just above window
    xfer(1'b0, 32'h1000_3FFF, 32'd0, 32'h7777_0001, 3);          // last byte of slot 3
    idle(1);

    // Stalled slave 1, then reset in the middle of ACCESS
    s_wait[1]    = 1_000_000;
    s_data[1]    = 32'hBAD0_BAD0;
    bus.transfer = 1'b1;
    bus.write    = 1'b0;
    bus.addr     = 32'h1000_1000;
    step();
    step();
    for (int k = 0; k < STALL; k++) begin
      chk("stall_penable", 32'(bus.PENABLE), 32'd1);
      chk("stall_psel", 32'(bus.PSEL), 32'h2);
      chk("stall_ready", 32'(bus.ready), 32'd0);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(bus.PSEL), 32'd0);
    chk("arst_penable", 32'(bus.PENABLE), 32'd0);
    chk("arst_ready", 32'(bus.ready), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    bus.transfer = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle(3);
    xfer(1'b0, 32'h1000_1000, 32'd0, 32'h0BAD_CAFE, 1);
    idle(1);

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 32'h1000_0000, 32'd0, 32'h0000_1234, TO - 1);     // PREADY on limit cycle wins
    idle(1);
    xfer(1'b0, 32'h1000_0000, 32'd0, 32'h0000_1234, 1_000_000);  // never ready -> abort
    idle(1);
    xfer(1'b1, 32'h1000_2000, 32'hFEED_0000, 32'd0, TO);         // exactly at limit -> abort
    idle(1);
`endif

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      if ($urandom_range(0, 4) != 0) a = BASE + 32'($urandom_range(0, 16383));
      else                           a = $urandom;
      xfer(wr, a, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator (bridge) converting a simple CPU-side request/ready bus into APB3 transfers.
- Decodes a fixed 16 KB peripheral window into up to four PSEL lines.
- Sequences SETUP/ACCESS phases and waits on PREADY from the selected slave.
- Returns read data and a completion strobe to the CPU.
- Drives the GPI/GPO/timer-style APB slaves in the SoC.

Parameters:
- NUM_SLAVES, 4, number of PSEL lines / slave ports (1..4).
- BASE_ADDR, 32'h1000_0000, peripheral window base; must be 16 KB aligned.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- transfer  in  1  CPU request; sampled only in IDLE.
- write  in  1  1 = write, 0 = read.
- addr  in  32  CPU byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ready = 1.
- ready  out  1  one-cycle completion strobe.
- err  out  1  error flag; valid with ready.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES x 32  per-slave read data (packed array).
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Reset (async on PRESETn low, any state):
  - FSM returns to IDLE immediately.
  - rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, PSEL all go to 0.
  - Any in-flight transfer is dropped with no completion strobe.
- Decode:
  - hit = addr[31:14] == BASE_ADDR[31:14] and addr[13:12] < NUM_SLAVES.
  - Slave index = addr[13:12].
  - PADDR carries the full latched address; slaves use the low bits.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: on transfer = 1, latch addr, wdata, write and the decode result into PADDR, PWDATA, PWRITE, then go to SETUP. transfer = 0 stays in IDLE.
  - SETUP, decode hit: PSEL[idx] = 1, PENABLE = 0, exactly one cycle, then ACCESS.
  - SETUP, decode miss: no PSEL asserted. Next cycle: ready = 1, err = 1, rdata = 0, go to IDLE.
  - ACCESS: PSEL[idx] = 1, PENABLE = 1; PADDR, PWDATA, PWRITE held stable. Stays in ACCESS until PREADY[idx] = 1 is sampled.
  - On PREADY[idx] sampled high:
    - Next cycle: ready = 1, err = 0, PSEL = 0, PENABLE = 0, state IDLE.
    - Read: rdata = PRDATA[idx] captured at that edge.
    - Write: rdata = 0.
  - PREADY/PRDATA of unselected slaves are ignored.
- Latency (registered-PREADY slave, which asserts PREADY one cycle into ACCESS):
  - transfer at cycle 0 → SETUP cycle 1 → ACCESS cycles 2–3 → ready at cycle 4.
  - Minimum latency with a zero-wait slave: 3 cycles.
- Request-side rules:
  - transfer asserted while not in IDLE is ignored.
  - Requester holds transfer until ready, then may drop it or reissue.
  - transfer high in the ready cycle starts a new transfer, since the FSM is already in IDLE; back-to-back transfers are allowed.
- ready and err are single-cycle pulses; both are 0 in every other cycle.
- Reset mid-ACCESS: PSEL/PENABLE deassert asynchronously; slave state is undefined by the master.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES without PREADY[idx], the transfer aborts: next cycle ready = 1, err = 1, rdata = 0, PSEL = 0, PENABLE = 0, state IDLE.
  - PREADY arriving on the same cycle as the limit wins (normal completion, err = 0).
- When undefined: ACCESS waits indefinitely; err is raised only on decode miss; no counter logic is synthesised.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e enum {IDLE, SETUP, ACCESS}
  - APB_ADDR_W = 32, APB_DATA_W = 32
  - APB_SLOT_LSB = 12, APB_WIN_LSB = 14
- Sub-module apb_master_mux: combinational select of PRDATA/PREADY by latched slave index, plus one-hot PSEL generation.

Test Plan:
- Write 32'hA5 to 32'h1000_0000 (slave 0, registered-PREADY model) → PSEL = 4'b0001; PENABLE low for 1 cycle then high; PWDATA = 32'hA5 stable; ready = 1, err = 0 at cycle 4.
- Read 32'h1000_2004 (slave 2 returns 32'h0000_003C) → PSEL = 4'b0100, PADDR = 32'h1000_2004, rdata = 32'h3C with ready; PSEL = 0 next cycle.
- Read 32'h2000_0000 (decode miss) → no PSEL ever asserted; ready = 1, err = 1, rdata = 0 two cycles after transfer.
- Back-to-back: write slave 1, then read slave 3 with transfer held high through ready → second SETUP immediately follows the ready cycle; PSEL goes 0010 → 0000 → 1000.
- PRESETn pulsed low during ACCESS with slave 1 stalled → PSEL, PENABLE, ready, err = 0 immediately; no ready pulse; next transfer completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave 0 never asserts PREADY → PENABLE high for 16 cycles, then ready = 1, err = 1, rdata = 0. Without the macro: still in ACCESS after 100 cycles.
